// File: rtl/phy_reg_freelist_pkg.sv
// Shared sizing for the physical register free list.
// The module and the testbench both size themselves from these values.
`timescale 1ns/1ps
package phy_reg_freelist_pkg;
  localparam int PHY_REG_NUM      = 64;
  localparam int ARCH_REG_NUM     = 32;
  localparam int RENAME_WIDTH     = 4;
  localparam int COMMIT_WIDTH     = 4;
  localparam int PHY_REG_ID_WIDTH = $clog2(PHY_REG_NUM);

  // Pointers carry one extra wrap bit, so full and empty can be told apart.
  localparam int PTR_WIDTH  = PHY_REG_ID_WIDTH + 1;
  localparam int FREE_CAP   = PHY_REG_NUM - ARCH_REG_NUM;
  localparam int RCNT_WIDTH = $clog2(RENAME_WIDTH) + 1;
  localparam int CCNT_WIDTH = $clog2(COMMIT_WIDTH) + 1;
endpackage

// File: rtl/phy_reg_freelist_popcount.sv
// Generic population count.
// Used for the rename pop mask and for the commit release mask.
`timescale 1ns/1ps
module phy_reg_freelist_popcount #(
  parameter int WIDTH = 4,
  localparam int CNT_W = $clog2(WIDTH) + 1
) (
  input  logic [WIDTH-1:0] bits_i,
  output logic [CNT_W-1:0] count_o
);
  always_comb begin
    count_o = '0;
    for (int i = 0; i < WIDTH; i++)
      count_o = count_o + CNT_W'(bits_i[i]);
  end
endmodule

// File: rtl/phy_reg_freelist.sv
// Circular free list of physical register IDs with speculative and committed heads.
// A flush snaps the speculative head back to the committed head in one cycle.
`timescale 1ns/1ps
module phy_reg_freelist
  import phy_reg_freelist_pkg::*;
(
  input  logic                                             clk,
  input  logic                                             rst,
  output logic [RENAME_WIDTH-1:0][PHY_REG_ID_WIDTH-1:0]    freelist_rename_new_phy_id,
  output logic [RENAME_WIDTH-1:0]                          freelist_rename_new_phy_id_valid,
  input  logic [RENAME_WIDTH-1:0]                          rename_freelist_pop_valid,
  input  logic                                             rename_freelist_pop,
  input  logic [COMMIT_WIDTH-1:0][PHY_REG_ID_WIDTH-1:0]    commit_freelist_release_id,
  input  logic [COMMIT_WIDTH-1:0]                          commit_freelist_release_valid,
  input  logic [CCNT_WIDTH-1:0]                            commit_freelist_retire_num,
  input  logic                                             commit_freelist_flush,
  output logic [PTR_WIDTH-1:0]                             freelist_free_count,
  output logic                                             freelist_error
);
  localparam int ID_W = PHY_REG_ID_WIDTH;

  logic [PHY_REG_NUM-1:0][ID_W-1:0] entries_q, entries_d;
  logic [PTR_WIDTH-1:0]  head_q, head_d;
  logic [PTR_WIDTH-1:0]  commit_head_q, commit_head_d;
  logic [PTR_WIDTH-1:0]  tail_q, tail_d;
  logic                  error_q, error_d;

  logic [PTR_WIDTH-1:0]  free_cnt;
  logic [RCNT_WIDTH-1:0] pop_cnt;
  logic [CCNT_WIDTH-1:0] rel_cnt;
  logic [CCNT_WIDTH-1:0] rank;
  logic                  pop_en, pop_bad, ret_bad, rel_bad;
  logic [PTR_WIDTH-1:0]  pop_adv, ret_adv, in_flight, occ_next;

  phy_reg_freelist_popcount #(.WIDTH(RENAME_WIDTH)) u_pop_cnt (
    .bits_i  (rename_freelist_pop_valid),
    .count_o (pop_cnt)
  );

  phy_reg_freelist_popcount #(.WIDTH(COMMIT_WIDTH)) u_rel_cnt (
    .bits_i  (commit_freelist_release_valid),
    .count_o (rel_cnt)
  );

  // Outputs depend only on registered state; releases show up a cycle later.
  assign free_cnt = tail_q - head_q;
  always_comb begin
    for (int i = 0; i < RENAME_WIDTH; i++) begin
      freelist_rename_new_phy_id[i]       = entries_q[head_q[ID_W-1:0] + ID_W'(i)];
      freelist_rename_new_phy_id_valid[i] = PTR_WIDTH'(i) < free_cnt;
    end
  end
  assign freelist_free_count = free_cnt;
  assign freelist_error      = error_q;

  // Pop: a popped channel must be offered and the mask must be a prefix.
  always_comb begin
    pop_en  = rename_freelist_pop && !commit_freelist_flush;
    pop_bad = pop_en &&
              ((|(rename_freelist_pop_valid & ~freelist_rename_new_phy_id_valid)) ||
               ((rename_freelist_pop_valid &
                 (rename_freelist_pop_valid + RENAME_WIDTH'(1))) != '0));
    pop_adv = '0;
    if (pop_en)
      pop_adv = (PTR_WIDTH'(pop_cnt) > free_cnt) ? free_cnt : PTR_WIDTH'(pop_cnt);
  end

  // Retire can never overtake the speculative head.
  always_comb begin
    in_flight     = head_q - commit_head_q;
    ret_bad       = PTR_WIDTH'(commit_freelist_retire_num) > in_flight;
    ret_adv       = ret_bad ? in_flight : PTR_WIDTH'(commit_freelist_retire_num);
    commit_head_d = commit_head_q + ret_adv;
  end

  // Release is checked against the post-retire committed head, so a
  // same-cycle retire makes room for the IDs it frees.
  always_comb begin
    occ_next = tail_q + PTR_WIDTH'(rel_cnt) - commit_head_d;
    rel_bad  = occ_next > PTR_WIDTH'(FREE_CAP);
    tail_d   = rel_bad ? tail_q : tail_q + PTR_WIDTH'(rel_cnt);
  end

  always_comb begin
    entries_d = entries_q;
    rank      = '0;
    for (int j = 0; j < COMMIT_WIDTH; j++) begin
      if (commit_freelist_release_valid[j]) begin
        if (!rel_bad)
          entries_d[tail_q[ID_W-1:0] + ID_W'(rank)] = commit_freelist_release_id[j];
        rank = rank + CCNT_WIDTH'(1);
      end
    end
  end

  always_comb begin
    head_d  = commit_freelist_flush ? commit_head_d : head_q + pop_adv;
    error_d = error_q | pop_bad | ret_bad | rel_bad;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int k = 0; k < PHY_REG_NUM; k++)
        entries_q[k] <= (k < FREE_CAP) ? ID_W'(ARCH_REG_NUM + k) : '0;
      head_q        <= '0;
      commit_head_q <= '0;
      tail_q        <= PTR_WIDTH'(FREE_CAP);
      error_q       <= 1'b0;
    end else begin
      entries_q     <= entries_d;
      head_q        <= head_d;
      commit_head_q <= commit_head_d;
      tail_q        <= tail_d;
      error_q       <= error_d;
    end
  end
endmodule

// File: tb/tb_phy_reg_freelist.sv
// Self-checking bench for phy_reg_freelist: vector table, corner sequences,
// and a long pop/release stream that wraps the pointers, all via a scoreboard.
`timescale 1ns/1ps
module tb_phy_reg_freelist;
  import phy_reg_freelist_pkg::*;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic                 rst;
  logic [3:0][5:0]      new_id;
  logic [3:0]           new_vld;
  logic [3:0]           pop_valid;
  logic                 pop;
  logic [3:0][5:0]      rel_id;
  logic [3:0]           rel_valid;
  logic [2:0]           retire_num;
  logic                 flush;
  logic [6:0]           free_count;
  logic                 err;

  phy_reg_freelist dut (
    .clk                              (clk),
    .rst                              (rst),
    .freelist_rename_new_phy_id       (new_id),
    .freelist_rename_new_phy_id_valid (new_vld),
    .rename_freelist_pop_valid        (pop_valid),
    .rename_freelist_pop              (pop),
    .commit_freelist_release_id       (rel_id),
    .commit_freelist_release_valid    (rel_valid),
    .commit_freelist_retire_num       (retire_num),
    .commit_freelist_flush            (flush),
    .freelist_free_count              (free_count),
    .freelist_error                   (err)
  );

  typedef struct {
    string      nm;
    logic       r;
    logic       p;
    logic [3:0] pv;
    logic [3:0] rv;
    logic [3:0][5:0] rid;
    logic [2:0] ret;
    logic       f;
    logic [3:0][5:0] eid;
    logic [3:0] ev;
    logic [6:0] ecnt;
    logic       eerr;
  } vec_t;

  int   checks = 0;
  int   errors = 0;
  vec_t sb[$];
  vec_t tbl[$];

  function automatic logic [3:0][5:0] seq4(input int b);
    logic [3:0][5:0] v;
    for (int i = 0; i < 4; i++) v[i] = 6'(b + i);
    return v;
  endfunction

  function automatic vec_t mk(input string nm, input logic r, input logic p,
      input logic [3:0] pv, input logic [3:0] rv, input logic [3:0][5:0] rid,
      input logic [2:0] ret, input logic f, input logic [3:0][5:0] eid,
      input logic [3:0] ev, input logic [6:0] ecnt, input logic eerr);
    vec_t v;
    v.nm = nm; v.r = r; v.p = p; v.pv = pv; v.rv = rv; v.rid = rid;
    v.ret = ret; v.f = f; v.eid = eid; v.ev = ev; v.ecnt = ecnt; v.eerr = eerr;
    return v;
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got %0d want %0d", nm, act, exp);
    end
  endtask

  task automatic run_vec(input vec_t v);
    vec_t e;
    @(negedge clk);
    rst = v.r; pop = v.p; pop_valid = v.pv; rel_valid = v.rv; rel_id = v.rid;
    retire_num = v.ret; flush = v.f;
    sb.push_back(v);
    @(posedge clk);
    #1;
    e = sb.pop_front();
    for (int i = 0; i < 4; i++)
      if (e.ev[i]) chk($sformatf("%s id%0d", e.nm, i), 32'(new_id[i]), 32'(e.eid[i]));
    chk({e.nm, " valid"}, 32'(new_vld), 32'(e.ev));
    chk({e.nm, " count"}, 32'(free_count), 32'(e.ecnt));
    chk({e.nm, " error"}, 32'(err), 32'(e.eerr));
  endtask

  logic [3:0][5:0] z, rid3, eid3;
  int fl[$];
  int popped[4];
  int prev[4];
  vec_t v;

  initial begin
    z = '0;
    rst = 1'b1; pop = 1'b0; pop_valid = '0; rel_valid = '0; rel_id = '0;
    retire_num = '0; flush = 1'b0;

    //         name      rst pop pv       rv       rid  ret   fl  exp ids     ev       cnt  err
    tbl.push_back(mk("reset",   1, 0, 4'b0000, 4'b0000, z, 3'd0, 0, seq4(32), 4'b1111, 32, 0));
    tbl.push_back(mk("idle",    0, 0, 4'b0000, 4'b0000, z, 3'd0, 0, seq4(32), 4'b1111, 32, 0));
    tbl.push_back(mk("pop3",    0, 1, 4'b0111, 4'b0000, z, 3'd0, 0, seq4(35), 4'b1111, 29, 0));
    tbl.push_back(mk("pop4",    0, 1, 4'b1111, 4'b0000, z, 3'd0, 0, seq4(39), 4'b1111, 25, 0));
    tbl.push_back(mk("ret2",    0, 0, 4'b0000, 4'b0000, z, 3'd2, 0, seq4(39), 4'b1111, 25, 0));
    tbl.push_back(mk("flret1",  0, 0, 4'b0000, 4'b0000, z, 3'd1, 1, seq4(35), 4'b1111, 29, 0));
    tbl.push_back(mk("flpop",   0, 1, 4'b1111, 4'b0000, z, 3'd0, 1, seq4(35), 4'b1111, 29, 0));
    tbl.push_back(mk("rst2",    1, 0, 4'b0000, 4'b0000, z, 3'd0, 0, seq4(32), 4'b1111, 32, 0));
    tbl.push_back(mk("t4pop1",  0, 1, 4'b1111, 4'b0000, z, 3'd0, 0, seq4(36), 4'b1111, 28, 0));
    tbl.push_back(mk("t4pop2",  0, 1, 4'b1111, 4'b0000, z, 3'd0, 0, seq4(40), 4'b1111, 24, 0));
    tbl.push_back(mk("t4flush", 0, 1, 4'b1111, 4'b0000, z, 3'd3, 1, seq4(35), 4'b1111, 29, 0));
    tbl.push_back(mk("rst3",    1, 0, 4'b0000, 4'b0000, z, 3'd0, 0, seq4(32), 4'b1111, 32, 0));
    tbl.push_back(mk("relovf",  0, 0, 4'b0000, 4'b0001, seq4(7), 3'd0, 0, seq4(32), 4'b1111, 32, 1));
    tbl.push_back(mk("sticky",  0, 0, 4'b0000, 4'b0000, z, 3'd0, 0, seq4(32), 4'b1111, 32, 1));
    tbl.push_back(mk("rst4",    1, 0, 4'b0000, 4'b0000, z, 3'd0, 0, seq4(32), 4'b1111, 32, 0));
    tbl.push_back(mk("nonpfx",  0, 1, 4'b0101, 4'b0000, z, 3'd0, 0, seq4(34), 4'b1111, 30, 1));
    tbl.push_back(mk("rst5",    1, 0, 4'b0000, 4'b0000, z, 3'd0, 0, seq4(32), 4'b1111, 32, 0));
    tbl.push_back(mk("retovf",  0, 0, 4'b0000, 4'b0000, z, 3'd1, 0, seq4(32), 4'b1111, 32, 1));
    tbl.push_back(mk("flclamp", 0, 0, 4'b0000, 4'b0000, z, 3'd0, 1, seq4(32), 4'b1111, 32, 1));
    tbl.push_back(mk("rst6",    1, 0, 4'b0000, 4'b0000, z, 3'd0, 0, seq4(32), 4'b1111, 32, 0));
    tbl.push_back(mk("prerst",  0, 1, 4'b1111, 4'b0000, z, 3'd0, 0, seq4(36), 4'b1111, 28, 0));
    tbl.push_back(mk("rstall",  1, 1, 4'b1111, 4'b1111, seq4(1), 3'd3, 1, seq4(32), 4'b1111, 32, 0));

    for (int n = 0; n < tbl.size(); n++) run_vec(tbl[n]);

    // Drain the list, then refill two IDs through a gapped release mask.
    run_vec(mk("t3rst", 1, 0, 4'b0000, 4'b0000, z, 3'd0, 0, seq4(32), 4'b1111, 32, 0));
    for (int k = 1; k <= 8; k++)
      run_vec(mk($sformatf("drain%0d", k), 0, 1, 4'b1111, 4'b0000, z, 3'd0, 0,
                 seq4(32 + 4 * k), (k < 8) ? 4'b1111 : 4'b0000, 7'(32 - 4 * k), 0));
    rid3 = '0; rid3[0] = 6'd63; rid3[1] = 6'd5; rid3[2] = 6'd63; rid3[3] = 6'd9;
    eid3 = '0; eid3[0] = 6'd5;  eid3[1] = 6'd9;
    run_vec(mk("refill", 0, 0, 4'b0000, 4'b1010, rid3, 3'd2, 0, eid3, 4'b0011, 2, 0));
    eid3 = '0; eid3[0] = 6'd9;
    run_vec(mk("popone", 0, 1, 4'b0001, 4'b0000, z, 3'd0, 0, eid3, 4'b0001, 1, 0));
    run_vec(mk("popover", 0, 1, 4'b0011, 4'b0000, z, 3'd0, 0, z, 4'b0000, 0, 1));

    // Steady pop/release stream against a FIFO model; wraps storage and pointers.
    run_vec(mk("wraprst", 1, 0, 4'b0000, 4'b0000, z, 3'd0, 0, seq4(32), 4'b1111, 32, 0));
    fl.delete();
    for (int k = 0; k < 32; k++) fl.push_back(32 + k);
    for (int c = 0; c < 40; c++) begin
      for (int i = 0; i < 4; i++) popped[i] = fl.pop_front();
      rid3 = '0;
      if (c > 0)
        for (int i = 0; i < 4; i++) begin
          rid3[i] = 6'(prev[i]);
          fl.push_back(prev[i]);
        end
      for (int i = 0; i < 4; i++) begin
        eid3[i] = 6'(fl[i]);
        prev[i] = popped[i];
      end
      v = mk($sformatf("wrap%0d", c), 0, 1, 4'b1111, (c > 0) ? 4'b1111 : 4'b0000, rid3,
             (c > 0) ? 3'd4 : 3'd0, 0, eid3, 4'b1111, 7'(fl.size()), 0);
      run_vec(v);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
